// File: rtl/rr_arb_mux_pkg.sv
// rr_arb_mux_pkg: arbitration mode encodings shared by the arbiter mux and its picker
package rr_arb_mux_pkg;
    localparam int ARB_MODE_RR  = 0;
    localparam int ARB_MODE_FIX = 1;
endpackage

// File: rtl/rr_arb_mux_pick.sv
// rr_pick: rotated priority search returning the first requester at or after base, wrapping at N-1
module rr_pick #(
    parameter int N    = 8,
    parameter int SELW = 3
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            mode,
    output logic [SELW-1:0] g,
    output logic            any
);
    logic [SELW-1:0] base;
    logic [N-1:0]    rot;
    int              p;
    int              s;
    always_comb begin
        base = mode ? '0 : ptr;
        rot  = N'({req, req} >> base);
        p    = 0;
        for (int i = N - 1; i >= 0; i--) p = rot[i] ? i : p;
        s    = p + int'(base);
        g    = SELW'(s >= N ? s - N : s);
    end
    assign any = |req;
endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready arbiter mux with a single registered output stage
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int SELW  = 3,
    parameter int MODE  = ARB_MODE_RR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);
    if (SELW < $clog2(N) || N < 2 || N > 16) begin : g_bad_param
        $error("rr_arb_mux: N must be 2..16 and SELW >= clog2(N)");
    end
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] g;
    logic            any;
    logic            accept;
    rr_pick #(.N(N), .SELW(SELW)) u_pick (
        .req  (in_valid),
        .ptr  (ptr),
        .mode (MODE == ARB_MODE_FIX),
        .g    (g),
        .any  (any)
    );
    assign accept   = !out_valid || out_ready;
    assign in_ready = (accept && any && !flush && !reset) ? N'(1) << g : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= any;
            if (any) begin
                out_data <= in_data[int'(g) * WIDTH +: WIDTH];
                out_sel  <= g;
                if (MODE == ARB_MODE_RR) ptr <= (g == SELW'(N - 1)) ? '0 : g + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed checks of round-robin, wrap, stall, fixed priority, flush and reset
module tb_rr_arb_mux;
    import rr_arb_mux_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    always #5 clk = ~clk;

    logic        fa = 1'b0, ora = 1'b1;
    logic [7:0]  va = 8'hFF, ra;
    logic [255:0] da;
    logic        ova;
    logic [31:0] oda;
    logic [2:0]  osa;
    rr_arb_mux #(.WIDTH(32), .N(8), .SELW(3), .MODE(ARB_MODE_RR)) u_a (
        .clk(clk), .reset(reset), .flush(fa), .in_valid(va), .in_data(da), .in_ready(ra),
        .out_valid(ova), .out_data(oda), .out_sel(osa), .out_ready(ora));

    logic        f5 = 1'b0, or5 = 1'b1;
    logic [4:0]  v5 = '0, r5;
    logic [159:0] d5;
    logic        ov5;
    logic [31:0] od5;
    logic [2:0]  os5;
    rr_arb_mux #(.WIDTH(32), .N(5), .SELW(3), .MODE(ARB_MODE_RR)) u_5 (
        .clk(clk), .reset(reset), .flush(f5), .in_valid(v5), .in_data(d5), .in_ready(r5),
        .out_valid(ov5), .out_data(od5), .out_sel(os5), .out_ready(or5));

    logic        ff = 1'b0, orf = 1'b1;
    logic [7:0]  vf = '0, rf;
    logic [255:0] df;
    logic        ovf;
    logic [31:0] odf;
    logic [2:0]  osf;
    rr_arb_mux #(.WIDTH(32), .N(8), .SELW(3), .MODE(ARB_MODE_FIX)) u_f (
        .clk(clk), .reset(reset), .flush(ff), .in_valid(vf), .in_data(df), .in_ready(rf),
        .out_valid(ovf), .out_data(odf), .out_sel(osf), .out_ready(orf));

    initial begin
        for (int i = 0; i < 8; i++) begin
            da[i*32 +: 32] = 32'hA0 + 32'(i);
            df[i*32 +: 32] = 32'hF0 + 32'(i);
        end
        for (int i = 0; i < 5; i++) d5[i*32 +: 32] = 32'h50 + 32'(i);
    end

    task automatic test_reset();
        repeat (2) begin
            @(negedge clk);
            n_cmp++; if (ova !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ova); end
            n_cmp++; if (ra !== 8'h00) begin n_err++; $display("FAIL reset_ready: got %h want 00", ra); end
        end
        reset = 1'b0;
        #1;
        n_cmp++; if (ra !== 8'h01) begin n_err++; $display("FAIL first_grant: got %h want 01", ra); end
    endtask

    task automatic test_rr_stream();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            n_cmp++; if (ova !== 1'b1 || osa !== 3'(k % 8)) begin n_err++; $display("FAIL rr_sel[%0d]: got v=%b sel=%0d want v=1 sel=%0d", k, ova, osa, k % 8); end
            n_cmp++; if (oda !== 32'hA0 + 32'(k % 8)) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", k, oda, 32'hA0 + 32'(k % 8)); end
            n_cmp++; if (ra !== 8'(1 << ((k + 1) % 8))) begin n_err++; $display("FAIL rr_ready[%0d]: got %h want %h", k, ra, 8'(1 << ((k + 1) % 8))); end
        end
        va = 8'h00;
        @(negedge clk);
        n_cmp++; if (ova !== 1'b0 || osa !== 3'd0) begin n_err++; $display("FAIL rr_drain: got v=%b sel=%0d want v=0 sel=0", ova, osa); end
    endtask

    task automatic test_wrap();
        v5 = 5'b00010;
        #1;
        n_cmp++; if (r5 !== 5'b00010) begin n_err++; $display("FAIL wrap_setup: got %b want 00010", r5); end
        @(negedge clk);
        n_cmp++; if (os5 !== 3'd1) begin n_err++; $display("FAIL wrap_setup_sel: got %0d want 1", os5); end
        v5 = 5'b10010;
        #1;
        n_cmp++; if (r5 !== 5'b10000) begin n_err++; $display("FAIL wrap_grant4: got %b want 10000", r5); end
        @(negedge clk);
        n_cmp++; if (os5 !== 3'd4 || od5 !== 32'h54) begin n_err++; $display("FAIL wrap_out4: got sel=%0d data=%h want 4/54", os5, od5); end
        n_cmp++; if (r5 !== 5'b00010) begin n_err++; $display("FAIL wrap_grant1: got %b want 00010", r5); end
        @(negedge clk);
        n_cmp++; if (os5 !== 3'd1 || od5 !== 32'h51) begin n_err++; $display("FAIL wrap_out1: got sel=%0d data=%h want 1/51", os5, od5); end
        v5 = 5'b00000;
    endtask

    task automatic test_stall();
        va = 8'h08; ora = 1'b0;
        @(negedge clk);
        va = 8'h20;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_cmp++; if (ova !== 1'b1 || osa !== 3'd3 || oda !== 32'hA3) begin n_err++; $display("FAIL stall_hold[%0d]: got v=%b sel=%0d data=%h want 1/3/a3", k, ova, osa, oda); end
            n_cmp++; if (ra !== 8'h00) begin n_err++; $display("FAIL stall_ready[%0d]: got %h want 00", k, ra); end
        end
        ora = 1'b1;
        #1;
        n_cmp++; if (ra !== 8'h20) begin n_err++; $display("FAIL stall_release_ready: got %h want 20", ra); end
        @(negedge clk);
        n_cmp++; if (ova !== 1'b1 || osa !== 3'd5 || oda !== 32'hA5) begin n_err++; $display("FAIL stall_pop_push: got v=%b sel=%0d data=%h want 1/5/a5", ova, osa, oda); end
        va = 8'h00;
        @(negedge clk);
        n_cmp++; if (ova !== 1'b0) begin n_err++; $display("FAIL stall_drain: got %b want 0", ova); end
    endtask

    task automatic test_fixed();
        vf = 8'b1010_0100;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (rf !== 8'h04) begin n_err++; $display("FAIL fix_ready[%0d]: got %h want 04", k, rf); end
            @(negedge clk);
            n_cmp++; if (ovf !== 1'b1 || osf !== 3'd2 || odf !== 32'hF2) begin n_err++; $display("FAIL fix_out[%0d]: got v=%b sel=%0d data=%h want 1/2/f2", k, ovf, osf, odf); end
        end
        vf = 8'h00;
    endtask

    task automatic test_flush();
        va = 8'h40; ora = 1'b0;
        @(negedge clk);
        n_cmp++; if (ova !== 1'b1 || osa !== 3'd6) begin n_err++; $display("FAIL flush_pre: got v=%b sel=%0d want 1/6", ova, osa); end
        fa = 1'b1; va = 8'h81; ora = 1'b1;
        #1;
        n_cmp++; if (ra !== 8'h00) begin n_err++; $display("FAIL flush_ready: got %h want 00", ra); end
        @(negedge clk);
        fa = 1'b0;
        n_cmp++; if (ova !== 1'b0 || osa !== 3'd6 || oda !== 32'hA6) begin n_err++; $display("FAIL flush_out: got v=%b sel=%0d data=%h want 0/6/a6", ova, osa, oda); end
        #1;
        n_cmp++; if (ra !== 8'h80) begin n_err++; $display("FAIL flush_ptr: got %h want 80", ra); end
        @(negedge clk);
        n_cmp++; if (ova !== 1'b1 || osa !== 3'd7 || oda !== 32'hA7) begin n_err++; $display("FAIL flush_after: got v=%b sel=%0d data=%h want 1/7/a7", ova, osa, oda); end
    endtask

    task automatic test_reset_mid();
        va = 8'h04;
        @(negedge clk);
        n_cmp++; if (ova !== 1'b1 || osa !== 3'd2) begin n_err++; $display("FAIL rmid_pre: got v=%b sel=%0d want 1/2", ova, osa); end
        ora = 1'b0; va = 8'h11; reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (ova !== 1'b0 || osa !== 3'd0 || oda !== 32'h0) begin n_err++; $display("FAIL rmid_out: got v=%b sel=%0d data=%h want 0/0/0", ova, osa, oda); end
        reset = 1'b0;
        #1;
        n_cmp++; if (ra !== 8'h01) begin n_err++; $display("FAIL rmid_ptr: got %h want 01", ra); end
        @(negedge clk);
        n_cmp++; if (ova !== 1'b1 || osa !== 3'd0 || oda !== 32'hA0) begin n_err++; $display("FAIL rmid_after: got v=%b sel=%0d data=%h want 1/0/a0", ova, osa, oda); end
        va = 8'h00; ora = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rr_stream();
        test_wrap();
        test_stall();
        test_fixed();
        test_flush();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
